// File: rtl/rv32i_pkg.sv
// Shared constants for the rv32i unified-memory arbiter.
// Owner codes tag which requester receives the next memory response.
package rv32i_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  function automatic logic [1:0] owner_of(
    input logic if_gnt,
    input logic d_gnt
  );
    if (d_gnt) return OWN_D;
    if (if_gnt) return OWN_IF;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/rv32i_arb_prio.sv
// Grant decision for the fetch/data ports of the unified memory.
// RV32I_MEM_ARB_RR_EN selects round-robin; otherwise data-first with a streak cap.
module rv32i_arb_prio
  import rv32i_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  logic d_win;

`ifdef RV32I_MEM_ARB_RR_EN

  gnt_e last_q, last_d;

  always_comb begin
    d_win = d_req_i & (~if_req_i | (last_q == GNT_IF));
  end

  always_comb begin
    last_d = last_q;
    if (d_gnt_o) begin
      last_d = GNT_D;
    end else if (if_gnt_o) begin
      last_d = GNT_IF;
    end
  end

  // Reset to D so fetch wins the first contested cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= GNT_D;
    end else begin
      last_q <= last_d;
    end
  end

`else

  localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

  logic [3:0] streak_q, streak_d;

  always_comb begin
    d_win = d_req_i & ~(if_req_i & (streak_q == MAX_S));
  end

  always_comb begin
    streak_d = streak_q;
    if (d_gnt_o & if_req_i) begin
      if (streak_q != MAX_S) begin
        streak_d = streak_q + 4'd1;
      end
    end else if (if_gnt_o | ~if_req_i) begin
      streak_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

`endif

  // Grants are held low while reset is asserted.
  always_comb begin
    d_gnt_o  = rst_ni & d_win;
    if_gnt_o = rst_ni & if_req_i & ~d_win;
  end

endmodule

// File: rtl/rv32i_mem_arb.sv
// Single-port memory arbiter between rv32i fetch and load/store ports.
// Optional round-robin arbitration: define RV32I_MEM_ARB_RR_EN.
module rv32i_mem_arb
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic              if_gnt, d_gnt;
  logic [1:0]        owner_q, owner_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] addr;

  rv32i_arb_prio #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_ni  (rst_in),
    .if_req_i(if_req_i),
    .d_req_i (d_req_i),
    .if_gnt_o(if_gnt),
    .d_gnt_o (d_gnt)
  );

  assign if_gnt_o = if_gnt;
  assign d_gnt_o  = d_gnt;

  always_comb begin
    addr        = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      d_gnt: begin
        addr        = d_addr_i;
        mem_be_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
      end
      if_gnt: begin
        addr     = if_addr_i;
        mem_be_o = BE_ALL;
      end
      default: ;
    endcase
  end

  assign mem_en_o   = if_gnt | d_gnt;
  assign mem_we_o   = d_gnt & d_we_i;
  assign mem_addr_o = addr & WORD_MASK;

  always_comb begin
    owner_d = owner_of(if_gnt, d_gnt);
    dwe_d   = d_gnt & d_we_i;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      owner_q <= OWN_NONE;
      dwe_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      dwe_q   <= dwe_d;
    end
  end

  // Writes still get an rvalid pulse, but never carry read data.
  always_comb begin
    if_rvalid_o = (owner_q == OWN_IF);
    d_rvalid_o  = (owner_q == OWN_D);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o   = (d_rvalid_o & ~dwe_q) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_rv32i_mem_arb.sv
// Self-checking bench for rv32i_mem_arb: vector table, corner
// sequences and a randomized run against a reference model.
module tb_rv32i_mem_arb;

  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  rv32i_mem_arb #(
    .ADDR_W(32),
    .MAX_DSTREAK(MAXD)
  ) dut (
    .clk_i      (clk),
    .rst_in     (rst_in),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_be_i     (d_be_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int   m_streak;
  bit   m_last_d;
  int   m_pend;
  bit   m_pend_we;
  bit   m_ig, m_dg;
  logic obs_dg;
  int   obs_rv;

  task automatic model_clear();
    m_streak  = 0;
    m_last_d  = 1'b1;
    m_pend    = 0;
    m_pend_we = 1'b0;
    m_ig      = 1'b0;
    m_dg      = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req_i  = 1'b0;
    if_addr_i = '0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_be_i    = '0;
    d_addr_i  = '0;
    d_wdata_i = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b1;
  endtask

  // Called at posedge+1 with inputs set; checks one cycle.
  task automatic cycle();
    bit ig, dg;
    logic [31:0] ea, ew, eird, edrd;
    logic [3:0] eb;
    @(negedge clk);
    if (if_req_i && d_req_i) begin
`ifdef RV32I_MEM_ARB_RR_EN
      dg = !m_last_d;
`else
      dg = (m_streak < MAXD);
`endif
      ig = !dg;
    end else begin
      ig = if_req_i;
      dg = d_req_i;
    end
    ea   = dg ? {d_addr_i[31:2], 2'b00} :
           ig ? {if_addr_i[31:2], 2'b00} : 32'h0;
    eb   = dg ? d_be_i : ig ? 4'hF : 4'h0;
    ew   = dg ? d_wdata_i : 32'h0;
    eird = (m_pend == 1) ? mem_rdata_i : 32'h0;
    edrd = (m_pend == 2 && !m_pend_we) ? mem_rdata_i : 32'h0;
    chk("if_gnt", 32'(if_gnt_o), 32'(ig));
    chk("d_gnt", 32'(d_gnt_o), 32'(dg));
    chk("mem_en", 32'(mem_en_o), 32'(ig | dg));
    chk("mem_we", 32'(mem_we_o), 32'(dg & d_we_i));
    chk("mem_be", 32'(mem_be_o), 32'(eb));
    chk("mem_addr", mem_addr_o, ea);
    chk("mem_wdata", mem_wdata_o, ew);
    chk("if_rvalid", 32'(if_rvalid_o), 32'(m_pend == 1));
    chk("if_rdata", if_rdata_o, eird);
    chk("d_rvalid", 32'(d_rvalid_o), 32'(m_pend == 2));
    chk("d_rdata", d_rdata_o, edrd);
    obs_dg = d_gnt_o;
    obs_rv += int'(if_rvalid_o) + int'(d_rvalid_o);
    m_ig = ig;
    m_dg = dg;
    @(posedge clk);
    m_pend    = dg ? 2 : ig ? 1 : 0;
    m_pend_we = dg & d_we_i;
    if (dg && if_req_i) begin
      m_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
    end else begin
      m_streak = 0;
    end
    if (ig) m_last_d = 1'b0;
    if (dg) m_last_d = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e_ig;
    logic        e_dg;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[6];
  bit   pat[10];

  initial begin
    rst_in      = 1'b0;
    mem_rdata_i = '0;
    idle_inputs();
    model_clear();

    vecs[0] = '{1, 32'h104, 0, 0, 4'h0, 0, 0, 32'h00A00093,
                1, 0, 32'h104, 0, 4'hF, 1, 0, 32'h00A00093, 0};
    vecs[1] = '{0, 0, 1, 1, 4'b0011, 32'h202, 32'hBEEF, 32'h12345678,
                0, 1, 32'h200, 1, 4'b0011, 0, 1, 0, 0};
    vecs[2] = '{0, 0, 1, 0, 4'hF, 32'h30C, 0, 32'hCAFEF00D,
                0, 1, 32'h30C, 0, 4'hF, 0, 1, 0, 32'hCAFEF00D};
`ifdef RV32I_MEM_ARB_RR_EN
    vecs[3] = '{1, 32'h40, 1, 0, 4'h1, 32'h81, 0, 32'h55,
                1, 0, 32'h40, 0, 4'hF, 1, 0, 32'h55, 0};
`else
    vecs[3] = '{1, 32'h40, 1, 0, 4'h1, 32'h81, 0, 32'h55,
                0, 1, 32'h80, 0, 4'h1, 0, 1, 0, 32'h55};
`endif
    vecs[4] = '{0, 32'h44, 0, 1, 4'hF, 32'h88, 32'h1, 32'h77,
                0, 0, 0, 0, 4'h0, 0, 0, 0, 0};
    vecs[5] = '{1, 32'h107, 0, 0, 4'h0, 0, 0, 32'hDEAD0001,
                1, 0, 32'h104, 0, 4'hF, 1, 0, 32'hDEAD0001, 0};

    foreach (vecs[i]) begin
      do_reset();
      if_req_i    = vecs[i].ifr;
      if_addr_i   = vecs[i].ia;
      d_req_i     = vecs[i].dr;
      d_we_i      = vecs[i].we;
      d_be_i      = vecs[i].be;
      d_addr_i    = vecs[i].da;
      d_wdata_i   = vecs[i].wd;
      mem_rdata_i = vecs[i].rd;
      @(negedge clk);
      chk("vec_if_gnt", 32'(if_gnt_o), 32'(vecs[i].e_ig));
      chk("vec_d_gnt", 32'(d_gnt_o), 32'(vecs[i].e_dg));
      chk("vec_addr", mem_addr_o, vecs[i].e_addr);
      chk("vec_we", 32'(mem_we_o), 32'(vecs[i].e_we));
      chk("vec_be", 32'(mem_be_o), 32'(vecs[i].e_be));
      @(posedge clk);
      #1;
      if_req_i = 1'b0;
      d_req_i  = 1'b0;
      @(negedge clk);
      chk("vec_if_rvalid", 32'(if_rvalid_o), 32'(vecs[i].e_irv));
      chk("vec_d_rvalid", 32'(d_rvalid_o), 32'(vecs[i].e_drv));
      chk("vec_if_rdata", if_rdata_o, vecs[i].e_ird);
      chk("vec_d_rdata", d_rdata_o, vecs[i].e_drd);
      @(posedge clk);
      #1;
    end

    // Reset during the response cycle of a data grant
    do_reset();
    d_req_i     = 1'b1;
    d_addr_i    = 32'h10;
    mem_rdata_i = 32'h600DF00D;
    @(negedge clk);
    chk("rst_pre_gnt", 32'(d_gnt_o), 32'd1);
    @(posedge clk);
    #1 rst_in = 1'b0;
    if_req_i = 1'b1;
    #1;
    chk("rst_ctl", 32'({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o,
                        mem_en_o, mem_we_o, mem_be_o}), 32'd0);
    chk("rst_data", if_rdata_o | d_rdata_o | mem_addr_o | mem_wdata_o,
        32'd0);
    @(posedge clk);
    #1 rst_in = 1'b1;
    idle_inputs();
    model_clear();
    @(negedge clk);
    chk("rst_no_rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
    @(posedge clk);
    #1;

    // Both requesters held high
`ifdef RV32I_MEM_ARB_RR_EN
    pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    do_reset();
    if_req_i  = 1'b1;
    if_addr_i = 32'h200;
    d_req_i   = 1'b1;
    d_addr_i  = 32'h400;
    d_be_i    = 4'hF;
    for (int k = 0; k < 10; k++) begin
      mem_rdata_i = 32'h1000 + 32'(k);
      cycle();
      chk("contend_seq", 32'(obs_dg), 32'(pat[k]));
    end

    // Back-to-back alternating data read / fetch
    do_reset();
    obs_rv = 0;
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k % 2 == 0) begin
        d_req_i  = 1'b1;
        d_be_i   = 4'hF;
        d_addr_i = 32'h300 + 32'(4 * k);
      end else begin
        if_req_i  = 1'b1;
        if_addr_i = 32'h100 + 32'(4 * k);
      end
      mem_rdata_i = 32'hA0000000 + 32'(k);
      cycle();
    end
    idle_inputs();
    mem_rdata_i = 32'hA0000008;
    cycle();
    chk("b2b_rvalid_cnt", 32'(obs_rv), 32'd8);

    // Randomized traffic, requests held until granted
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!(if_req_i && !m_ig)) begin
        if_req_i  = ($urandom % 3) != 0;
        if_addr_i = $urandom;
      end
      if (!(d_req_i && !m_dg)) begin
        d_req_i   = ($urandom % 3) != 0;
        d_we_i    = $urandom % 2;
        d_be_i    = 4'($urandom);
        d_addr_i  = $urandom;
        d_wdata_i = $urandom;
      end
      mem_rdata_i = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
